// File: rtl/mul_iter_param.sv
// Iterative shift-add multiplier producing a 2*WIDTH-bit signed/unsigned product,
// retiring STEP multiplier bits per cycle, with flush cancel and a busy indicator.
module mul_iter_param #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mul_signed,
  input  logic [WIDTH-1:0]     ina,
  input  logic [WIDTH-1:0]     inb,
  input  logic                 start_m,
  input  logic                 cancel_m,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready_m,
  output logic                 busy_m
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_param
      $error("mul_iter_param: STEP must be 1, 2 or 4 and must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   acc, mcand, addend, fixed;
  logic [WIDTH-1:0]     mplier, mag_a, mag_b;
  logic                 negate;
  logic [CW-1:0]        count;

  // The most negative operand negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    mag_a = (mul_signed && ina[WIDTH-1]) ? -ina : ina;
    mag_b = (mul_signed && inb[WIDTH-1]) ? -inb : inb;
    fixed = negate ? -acc : acc;
  end

  always_comb begin
    addend = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) begin
        addend = addend + (mcand << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cancel overrides every forward transition once an operation has been accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_m && !cancel_m) state_next = BUSY;
      BUSY: begin
        if (cancel_m)           state_next = IDLE;
        else if (count == LAST) state_next = FIX;
      end
      FIX:  state_next = cancel_m ? IDLE : DONE;
      DONE: if (cancel_m || !start_m) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      negate  <= 1'b0;
      count   <= '0;
      result  <= '0;
      ready_m <= 1'b0;
      busy_m  <= 1'b0;
    end else begin
      ready_m <= (state_next == DONE);
      busy_m  <= (state_next == BUSY) || (state_next == FIX);
      if (state_next != DONE) begin
        result <= '0;
      end else if (state == FIX) begin
        result <= fixed;
      end

      case (state)
        IDLE: begin
          if (state_next == BUSY) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            negate <= mul_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
            count  <= '0;
          end
        end
        BUSY: begin
          acc    <= acc + addend;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_param.sv
// Bench for mul_iter_param: four builds (32/1, 32/2, 32/4, 16/4) share one stimulus stream and
// are checked every cycle against a latency-countdown model plus directed literal checks.
module tb_mul_iter_param;

  logic        clk = 1'b0;
  logic        rst, mul_signed, start_m, cancel_m;
  logic [31:0] ina, inb;

  logic [63:0] res_s1, res_s2, res_s4;
  logic [31:0] res_w16;
  logic        rdy_s1, rdy_s2, rdy_s4, rdy_w16;
  logic        bsy_s1, bsy_s2, bsy_s4, bsy_w16;

  logic [63:0] dres [4];
  logic        drdy [4];
  logic        dbsy [4];

  int vectors     = 0;
  int miscompares = 0;

  localparam int NW  [4] = '{32, 32, 32, 16};
  localparam int LAT [4] = '{33, 17, 9, 5};

  always #5 clk = ~clk;

  mul_iter_param #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .mul_signed(mul_signed), .ina(ina), .inb(inb),
    .start_m(start_m), .cancel_m(cancel_m), .result(res_s1), .ready_m(rdy_s1), .busy_m(bsy_s1));
  mul_iter_param #(.WIDTH(32), .STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .mul_signed(mul_signed), .ina(ina), .inb(inb),
    .start_m(start_m), .cancel_m(cancel_m), .result(res_s2), .ready_m(rdy_s2), .busy_m(bsy_s2));
  mul_iter_param #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .mul_signed(mul_signed), .ina(ina), .inb(inb),
    .start_m(start_m), .cancel_m(cancel_m), .result(res_s4), .ready_m(rdy_s4), .busy_m(bsy_s4));
  mul_iter_param #(.WIDTH(16), .STEP(4)) u_w16 (
    .clk(clk), .rst(rst), .mul_signed(mul_signed), .ina(ina[15:0]), .inb(inb[15:0]),
    .start_m(start_m), .cancel_m(cancel_m), .result(res_w16), .ready_m(rdy_w16), .busy_m(bsy_w16));

  always_comb begin
    dres[0] = res_s1;  drdy[0] = rdy_s1;  dbsy[0] = bsy_s1;
    dres[1] = res_s2;  drdy[1] = rdy_s2;  dbsy[1] = bsy_s2;
    dres[2] = res_s4;  drdy[2] = rdy_s4;  dbsy[2] = bsy_s4;
    dres[3] = {32'h0, res_w16}; drdy[3] = rdy_w16; dbsy[3] = bsy_w16;
  end

  // Reference product: sign/zero-extend to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn, input int w);
    logic [63:0] ea, eb, p;
    if (w == 16) begin
      ea = sgn ? {{48{a[15]}}, a[15:0]} : {48'h0, a[15:0]};
      eb = sgn ? {{48{b[15]}}, b[15:0]} : {48'h0, b[15:0]};
    end else begin
      ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    end
    p = ea * eb;
    if (w == 16) p = {32'h0, p[31:0]};
    return p;
  endfunction

  // Model: cycles left until the product shows, whether it is being shown, and its value.
  int          m_wait [4];
  bit          m_hold [4];
  logic [63:0] m_prod [4];
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_wait[k] = 0;
        m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
        if (cancel_m || !start_m) m_hold[k] = 1'b0;
      end else if (m_wait[k] > 0) begin
        if (cancel_m) m_wait[k] = 0;
        else begin
          m_wait[k] = m_wait[k] - 1;
          if (m_wait[k] == 0) m_hold[k] = 1'b1;
        end
      end else if (start_m && !cancel_m) begin
        m_wait[k] = LAT[k];
        m_prod[k] = golden(ina, inb, mul_signed, NW[k]);
      end
    end
    if (rst) m_live = 1'b1;
  end

  always begin
    @(posedge clk);
    #1;
    if (m_live) begin
      for (int k = 0; k < 4; k++) begin
        logic [63:0] exp_res;
        logic        exp_busy;
        exp_res  = m_hold[k] ? m_prod[k] : 64'h0;
        exp_busy = (m_wait[k] > 0);
        vectors++;
        if (dres[k] !== exp_res || drdy[k] !== m_hold[k] || dbsy[k] !== exp_busy) begin
          miscompares++;
          $display("[TB] FAIL cycle dut%0d t=%0t: got res=%h rdy=%b busy=%b, expected res=%h rdy=%b busy=%b",
                   k, $time, dres[k], drdy[k], dbsy[k], exp_res, m_hold[k], exp_busy);
        end
      end
    end
  end

  function automatic bit allIdle();
    for (int k = 0; k < 4; k++) if (m_wait[k] != 0 || m_hold[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit allHold();
    for (int k = 0; k < 4; k++) if (!m_hold[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    ina = a; inb = b; mul_signed = sgn;
    start_m = 1'b1; cancel_m = 1'b0;
  endtask

  // Expects start_m already high; the next edge is the capture edge.
  task automatic measureOp(input logic [63:0] exp64, input logic [31:0] exp16, input int hold);
    int lat [4];
    int cyc;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    @(posedge clk);
    #1;
    checkOutput("busy after capture", {63'h0, bsy_s1}, 64'h1);
    ina = $urandom; inb = $urandom; mul_signed = ~mul_signed;
    cyc = 0;
    while (cyc < 60 && lat[0] == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) if (drdy[k] === 1'b1 && lat[k] == 0) lat[k] = cyc;
    end
    for (int k = 0; k < 4; k++) checkOutput($sformatf("latency dut%0d", k), 64'(lat[k]), 64'(LAT[k]));
    checkOutput("product 32/1", res_s1, exp64);
    checkOutput("product 16/4", {32'h0, res_w16}, {32'h0, exp16});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput("held product", res_s1, exp64);
      checkOutput("held ready", {63'h0, rdy_s1}, 64'h1);
    end
    @(negedge clk);
    start_m = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready after drop", {63'h0, rdy_s1}, 64'h0);
    checkOutput("result after drop", res_s1, 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_m = 1'b0; cancel_m = 1'b0; mul_signed = 1'b0; ina = '0; inb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result", res_s1, 64'h0);
    checkOutput("reset ready", {63'h0, rdy_s1}, 64'h0);
    checkOutput("reset busy", {63'h0, bsy_s1}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    measureOp(64'hFFFF_FFFE_0000_0001, 32'hFFFE_0001, 5);
    applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1);
    measureOp(64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFF1, 0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    measureOp(64'h1, 32'h1, 0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    measureOp(64'h4000_0000_0000_0000, 32'h0, 0);
    applyStimulus(32'h8000_0000, 32'h1, 1'b1);
    measureOp(64'hFFFF_FFFF_8000_0000, 32'h0, 0);
    applyStimulus(32'h0, 32'hFFFF_FFF9, 1'b1);
    measureOp(64'h0, 32'h0, 0);

    // Cancel after ten iterations, then immediately start 7 x 6.
    applyStimulus(32'd1000, 32'd1000, 1'b0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel_m = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cancel busy", {63'h0, bsy_s1}, 64'h0);
    checkOutput("cancel ready", {63'h0, rdy_s1}, 64'h0);
    @(negedge clk);
    cancel_m = 1'b0; ina = 32'd7; inb = 32'd6; mul_signed = 1'b0;
    measureOp(64'd42, 32'd42, 0);

    @(negedge clk);
    start_m = 1'b1; cancel_m = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("cancel blocks capture", {63'h0, bsy_s1}, 64'h0);
    end
    @(negedge clk);
    start_m = 1'b0; cancel_m = 1'b0;

    // Reset in the middle of an operation, then a clean unsigned product.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset result", res_s1, 64'h0);
    checkOutput("mid reset busy", {63'h0, bsy_s1}, 64'h0);
    checkOutput("mid reset ready 16/4", {63'h0, rdy_w16}, 64'h0);
    @(negedge clk);
    rst = 1'b0; ina = 32'd12345; inb = 32'd678; mul_signed = 1'b0;
    measureOp(64'd8369910, 32'd8369910, 0);

    // Random operations with cancels, early start drops and variable hold times.
    for (int i = 0; i < 300; i++) begin
      int mode;
      for (int w = 0; w < 100 && !allIdle(); w++) @(negedge clk);
      applyStimulus(pick(), pick(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      ina = $urandom; inb = $urandom; mul_signed = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        cancel_m = 1'b1;
        @(negedge clk);
        cancel_m = 1'b0; start_m = 1'b0;
      end else if (mode == 1) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        start_m = 1'b0;
      end else begin
        for (int w = 0; w < 60 && !allHold(); w++) @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_m = 1'b0;
      end
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
